// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control stage.
//   - Controller state encoding (FETCH / EXEC / MWAIT).
//   - Bit positions of the fields inside a Hack instruction word.
//   - Jump-field mnemonics, JGT (001) through JMP (111).
package hack_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MWAIT = 2'd2
    } state_e;

    // Instruction field positions
    localparam int CI_BIT     = 15;   // 1 = C-instruction, 0 = A-instruction
    localparam int A_BIT      = 12;   // ALU y operand: 1 = inM, 0 = A
    localparam int COMP_HI    = 11;
    localparam int COMP_LO    = 6;
    localparam int DEST_A_BIT = 5;    // d1
    localparam int DEST_D_BIT = 4;    // d2
    localparam int DEST_M_BIT = 3;    // d3
    localparam int JMP_HI     = 2;
    localparam int JMP_LO     = 0;

    // Jump mnemonics {j1,j2,j3}
    localparam logic [2:0] JNULL = 3'b000;
    localparam logic [2:0] JGT   = 3'b001;
    localparam logic [2:0] JEQ   = 3'b010;
    localparam logic [2:0] JGE   = 3'b011;
    localparam logic [2:0] JLT   = 3'b100;
    localparam logic [2:0] JNE   = 3'b101;
    localparam logic [2:0] JLE   = 3'b110;
    localparam logic [2:0] JMP   = 3'b111;

endpackage

// File: rtl/hack_jump_unit.sv
// Hack jump resolution, purely combinational.
// Ports:
//   j    in  3  jump field {j1,j2,j3}
//   zr   in  1  ALU zero flag
//   ng   in  1  ALU negative flag
//   take out 1  jump taken: (j1&ng) | (j2&zr) | (j3&~ng&~zr)
module hack_jump_unit
    import hack_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    // Per-mnemonic expansion of the OR of the three enabled conditions
    always_comb begin
        take = 1'b0;
        case (j)
            JNULL:   take = 1'b0;
            JGT:     take = ~ng & ~zr;
            JEQ:     take = zr;
            JGE:     take = zr | ~ng;
            JLT:     take = ng;
            JNE:     take = ng | ~zr;
            JLE:     take = ng | zr;
            JMP:     take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multicycle control/register stage sitting in front of the Hack ALU.
// Fetches and decodes instructions, holds A, D and PC, drives the ALU
// operands/controls, and applies the ALU result to registers, data memory
// and the program counter.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   imem_req, pc      fetch request (FETCH only) and instruction address
//   instr, instr_valid returned instruction word and its valid strobe
//   inM               data memory read value
//   alu_x, alu_y      ALU operands (D, and A or inM)
//   alu_ctrl          {zx,nx,zy,ny,f,no}, zero for A-instructions
//   alu_out, alu_zr, alu_ng  ALU result and flags
//   outM, writeM, addressM   registered data memory write port
//   mem_ack           data memory accepted the write (used in MWAIT only)
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter int PC_W   = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] inM,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [5:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [DATA_W-1:0] outM,
    output logic              writeM,
    output logic [PC_W-1:0]   addressM,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_reg_q, a_reg_d;
    logic [DATA_W-1:0] d_reg_q, d_reg_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   tgt_q, tgt_d;        // PC to apply once the memory write completes
    logic [DATA_W-1:0] out_m_q, out_m_d;
    logic [PC_W-1:0]   addr_m_q, addr_m_d;
    logic              write_m_q, write_m_d;

    logic              take_s;
    logic [PC_W-1:0]   pc_inc_s;
    logic [PC_W-1:0]   pc_next_s;

    hack_jump_unit u_jump (
        .j    (ir_q[JMP_HI:JMP_LO]),
        .zr   (alu_zr),
        .ng   (alu_ng),
        .take (take_s)
    );

    // Wraps 0x7FFF -> 0x0000 naturally in PC_W bits
    assign pc_inc_s  = pc_q + PC_W'(1);
    // Jump target is the A value from before this instruction's own A update
    assign pc_next_s = take_s ? a_reg_q[PC_W-1:0] : pc_inc_s;

    assign imem_req = (state_q == ST_FETCH);
    assign pc       = pc_q;
    assign alu_x    = d_reg_q;
    assign alu_y    = ir_q[A_BIT] ? inM : a_reg_q;
    assign alu_ctrl = ir_q[CI_BIT] ? ir_q[COMP_HI:COMP_LO] : 6'b000000;
    assign outM     = out_m_q;
    assign writeM   = write_m_q;
    assign addressM = addr_m_q;

    // Next-state and register-update logic for the FETCH/EXEC/MWAIT sequence
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        a_reg_d   = a_reg_q;
        d_reg_d   = d_reg_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        out_m_d   = out_m_q;
        addr_m_d  = addr_m_q;
        write_m_d = write_m_q;

        case (state_q)
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_EXEC: begin
                if (!ir_q[CI_BIT]) begin
                    a_reg_d = {1'b0, ir_q[DATA_W-2:0]};
                    pc_d    = pc_inc_s;
                    state_d = ST_FETCH;
                end else begin
                    if (ir_q[DEST_A_BIT]) begin
                        a_reg_d = alu_out;
                    end else begin
                        a_reg_d = a_reg_q;
                    end
                    if (ir_q[DEST_D_BIT]) begin
                        d_reg_d = alu_out;
                    end else begin
                        d_reg_d = d_reg_q;
                    end
                    if (ir_q[DEST_M_BIT]) begin
                        // PC is held until the write is acknowledged
                        out_m_d   = alu_out;
                        addr_m_d  = a_reg_q[PC_W-1:0];
                        write_m_d = 1'b1;
                        tgt_d     = pc_next_s;
                        state_d   = ST_MWAIT;
                    end else begin
                        pc_d    = pc_next_s;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_MWAIT: begin
                if (mem_ack) begin
                    write_m_d = 1'b0;
                    pc_d      = tgt_q;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_MWAIT;
                end
            end

            default: begin
                write_m_d = 1'b0;
                state_d   = ST_FETCH;
            end
        endcase
    end

    // State and datapath registers; reset overrides any in-flight fetch or write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            a_reg_q   <= '0;
            d_reg_q   <= '0;
            pc_q      <= '0;
            tgt_q     <= '0;
            out_m_q   <= '0;
            addr_m_q  <= '0;
            write_m_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            a_reg_q   <= a_reg_d;
            d_reg_q   <= d_reg_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            out_m_q   <= out_m_d;
            addr_m_q  <= addr_m_d;
            write_m_q <= write_m_d;
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl. A behavioural Hack ALU sits beside
// the DUT; a table of instructions with hand-computed results drives the
// main program, and hand-written sequences cover memory writes and reset.
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [14:0] pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] inM;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctrl;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic        mem_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hack_cpu_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .inM         (inM),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_ctrl    (alu_ctrl),
        .alu_out     (alu_out),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .mem_ack     (mem_ack)
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x_in, input logic [15:0] y_in,
                                             input logic [5:0] c);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] o;
        x = c[5] ? 16'h0000 : x_in;
        x = c[4] ? ~x : x;
        y = c[3] ? 16'h0000 : y_in;
        y = c[2] ? ~y : y;
        o = c[1] ? (x + y) : (x & y);
        o = c[0] ? ~o : o;
        return o;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, alu_ctrl);
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];

    typedef struct {
        logic [15:0] instr;
        logic        stall;
        logic [5:0]  exp_ctrl;
        logic [14:0] exp_pc;
        logic [15:0] exp_d;
        logic [15:0] exp_a;
    } vec_t;

    vec_t vt [0:24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Run one non-writing instruction from FETCH to the following FETCH
    task automatic apply_vec(input int i);
        logic [5:0] ctrl_seen;
        logic       req_seen;
        inM = 16'h0000;
        if (vt[i].stall) begin
            instr_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("v%0d stall_req", i), {31'd0, imem_req}, 32'd1);
            chk($sformatf("v%0d stall_pc", i), {17'd0, pc}, {17'd0, vt[i-1].exp_pc});
        end
        instr = vt[i].instr;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        ctrl_seen = alu_ctrl;
        req_seen  = imem_req;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d ctrl", i), {26'd0, ctrl_seen}, {26'd0, vt[i].exp_ctrl});
        chk($sformatf("v%0d exec_req", i), {31'd0, req_seen}, 32'd0);
        chk($sformatf("v%0d pc", i), {17'd0, pc}, {17'd0, vt[i].exp_pc});
        chk($sformatf("v%0d D", i), {16'd0, alu_x}, {16'd0, vt[i].exp_d});
        if (!vt[i].instr[12]) begin
            chk($sformatf("v%0d A", i), {16'd0, alu_y}, {16'd0, vt[i].exp_a});
        end
        chk($sformatf("v%0d writeM", i), {31'd0, writeM}, 32'd0);
        chk($sformatf("v%0d fetch_req", i), {31'd0, imem_req}, 32'd1);
    endtask

    // Run a C-instruction with d3 set, holding off mem_ack for 'waits' cycles
    task automatic mem_instr(input string nm, input logic [15:0] ins, input logic [15:0] m,
                             input logic [15:0] exp_out, input logic [14:0] exp_addr,
                             input logic [14:0] exp_pc_hold, input logic [14:0] exp_pc_after,
                             input int waits);
        inM = m;
        mem_ack = 1'b0;
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int w = 0; w < waits; w++) begin
            chk($sformatf("%s w%0d writeM", nm, w), {31'd0, writeM}, 32'd1);
            chk($sformatf("%s w%0d outM", nm, w), {16'd0, outM}, {16'd0, exp_out});
            chk($sformatf("%s w%0d addressM", nm, w), {17'd0, addressM}, {17'd0, exp_addr});
            chk($sformatf("%s w%0d pc", nm, w), {17'd0, pc}, {17'd0, exp_pc_hold});
            chk($sformatf("%s w%0d req", nm, w), {31'd0, imem_req}, 32'd0);
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk($sformatf("%s ack writeM", nm), {31'd0, writeM}, 32'd0);
        chk($sformatf("%s ack pc", nm), {17'd0, pc}, {17'd0, exp_pc_after});
        chk($sformatf("%s ack req", nm), {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          instr     stall ctrl        pc        D         A
        vt[0]  = '{16'h0005, 1'b0, 6'b000000, 15'h0001, 16'h0000, 16'h0005};
        vt[1]  = '{16'hEC10, 1'b0, 6'b110000, 15'h0002, 16'h0005, 16'h0005};
        vt[2]  = '{16'h0010, 1'b1, 6'b000000, 15'h0003, 16'h0005, 16'h0010};
        vt[3]  = '{16'hE301, 1'b0, 6'b001100, 15'h0010, 16'h0005, 16'h0010};
        vt[4]  = '{16'hEA90, 1'b0, 6'b101010, 15'h0011, 16'h0000, 16'h0010};
        vt[5]  = '{16'hE301, 1'b0, 6'b001100, 15'h0012, 16'h0000, 16'h0010};
        vt[6]  = '{16'h0005, 1'b0, 6'b000000, 15'h0013, 16'h0000, 16'h0005};
        vt[7]  = '{16'hECD0, 1'b0, 6'b110011, 15'h0014, 16'hFFFB, 16'h0005};
        vt[8]  = '{16'h0010, 1'b1, 6'b000000, 15'h0015, 16'hFFFB, 16'h0010};
        vt[9]  = '{16'hE304, 1'b0, 6'b001100, 15'h0010, 16'hFFFB, 16'h0010};
        vt[10] = '{16'hE301, 1'b0, 6'b001100, 15'h0011, 16'hFFFB, 16'h0010};
        vt[11] = '{16'h0030, 1'b0, 6'b000000, 15'h0012, 16'hFFFB, 16'h0030};
        vt[12] = '{16'hE327, 1'b0, 6'b001100, 15'h0030, 16'hFFFB, 16'hFFFB};
        vt[13] = '{16'h0020, 1'b0, 6'b000000, 15'h0031, 16'hFFFB, 16'h0020};
        // after AM=M+1;JMP: A = 0x42, pc = 0x20
        vt[14] = '{16'hEC10, 1'b0, 6'b110000, 15'h0021, 16'h0042, 16'h0042};
        vt[15] = '{16'h0005, 1'b0, 6'b000000, 15'h0022, 16'h0042, 16'h0005};
        vt[16] = '{16'hEC10, 1'b1, 6'b110000, 15'h0023, 16'h0005, 16'h0005};
        vt[17] = '{16'h0003, 1'b0, 6'b000000, 15'h0024, 16'h0005, 16'h0003};
        // after M=D+A: pc = 0x25
        vt[18] = '{16'h7FFF, 1'b0, 6'b000000, 15'h0026, 16'h0005, 16'h7FFF};
        vt[19] = '{16'hEA87, 1'b0, 6'b101010, 15'h7FFF, 16'h0005, 16'h7FFF};
        vt[20] = '{16'h0001, 1'b0, 6'b000000, 15'h0000, 16'h0005, 16'h0001};
        vt[21] = '{16'h0002, 1'b0, 6'b000000, 15'h0001, 16'h0005, 16'h0002};
        vt[22] = '{16'hEA87, 1'b0, 6'b101010, 15'h0002, 16'h0005, 16'h0002};
        vt[23] = '{16'hEA87, 1'b0, 6'b101010, 15'h0002, 16'h0005, 16'h0002};
        vt[24] = '{16'hEA87, 1'b0, 6'b101010, 15'h0002, 16'h0005, 16'h0002};

        // T1: reset held two cycles with a valid instruction present
        reset = 1'b1;
        instr = 16'hEA87;
        instr_valid = 1'b1;
        inM = 16'h0000;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        instr_valid = 1'b0;
        chk("rst pc", {17'd0, pc}, 32'd0);
        chk("rst D", {16'd0, alu_x}, 32'd0);
        chk("rst A", {16'd0, alu_y}, 32'd0);
        chk("rst writeM", {31'd0, writeM}, 32'd0);
        chk("rst outM", {16'd0, outM}, 32'd0);
        chk("rst addressM", {17'd0, addressM}, 32'd0);
        chk("rst req", {31'd0, imem_req}, 32'd1);

        // T2/T4 and old-A jump without memory write
        for (int i = 0; i <= 13; i++) apply_vec(i);

        // T5: AM=M+1;JMP with A=0x20, M=0x41 -> writes 0x42 to 0x20, jumps to old A
        mem_instr("amjmp", 16'hFDEF, 16'h0041, 16'h0042, 15'h0020, 15'h0031, 15'h0020, 1);

        for (int i = 14; i <= 17; i++) apply_vec(i);

        // T3: M=D+A with D=5, A=3, ack withheld for three cycles
        mem_instr("mdpa", 16'hE088, 16'h0000, 16'h0008, 15'h0003, 15'h0024, 15'h0025, 3);

        // T6 wrap at 0x7FFF, then the self-jump halt idiom at pc 2
        for (int i = 18; i <= 24; i++) apply_vec(i);

        // T6: reset during MWAIT (D=5, A=2 -> M=7 at address 2)
        inM = 16'h0000;
        instr = 16'hE088;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mwait writeM", {31'd0, writeM}, 32'd1);
        chk("mwait outM", {16'd0, outM}, 32'h7);
        chk("mwait addressM", {17'd0, addressM}, 32'h2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mrst writeM", {31'd0, writeM}, 32'd0);
        chk("mrst pc", {17'd0, pc}, 32'd0);
        chk("mrst outM", {16'd0, outM}, 32'd0);
        chk("mrst addressM", {17'd0, addressM}, 32'd0);
        chk("mrst D", {16'd0, alu_x}, 32'd0);
        chk("mrst req", {31'd0, imem_req}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
